// File: rtl/decode_exec_unit.sv
// decode_exec_unit: 4-bit accumulator execute stage.
// Sequences fetch, execute and two-byte jumps for the fetch register and PC.
module decode_exec_unit #(
  parameter bit SUB_BORROW_C = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [3:0]  instr,
  input  logic [3:0]  oprnd,
  input  logic [7:0]  program_byte,
  input  logic [3:0]  data_in,
  output logic        fetch_en,
  output logic        pc_en,
  output logic        pc_load,
  output logic [11:0] pc_addr,
  output logic [3:0]  acc,
  output logic        flag_c,
  output logic        flag_z,
  output logic [3:0]  data_out,
  output logic        out_strobe
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    JADDR
  } state_t;

  state_t     r_state;
  logic [3:0] r_acc;
  logic [3:0] r_dout;
  logic [3:0] r_hi;
  logic       r_c;
  logic       r_z;
  logic       r_take;
  logic       r_strb;

  logic [4:0] w_sum;
  logic [4:0] w_diff;
  logic [3:0] w_nand;
  logic       w_c_sub;
  logic       w_jmp;
  logic       w_cond;

  assign w_sum   = {1'b0, r_acc} + {1'b0, oprnd};
  assign w_diff  = {1'b0, r_acc} - {1'b0, oprnd};
  assign w_nand  = ~(r_acc & oprnd);
  assign w_c_sub = SUB_BORROW_C ? w_diff[4] : ~w_diff[4];

  // Jump conditions see the flags as they were before this instruction
  always_comb begin
    w_jmp  = 1'b1;
    w_cond = 1'b0;
    unique case (instr)
      4'h8:    w_cond = r_c;
      4'h9:    w_cond = ~r_c;
      4'hA:    w_cond = r_z;
      4'hB:    w_cond = ~r_z;
      4'hC:    w_cond = 1'b1;
      default: w_jmp  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_acc   <= 4'h0;
      r_dout  <= 4'h0;
      r_hi    <= 4'h0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_take  <= 1'b0;
      r_strb  <= 1'b0;
    end else begin
      r_strb <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (run) r_state <= FETCH;
        end
        FETCH: begin
          r_state <= EXEC;
        end
        EXEC: begin
          r_take <= w_cond;
          r_hi   <= oprnd;
          case (instr)
            4'h1: begin
              r_acc <= oprnd;
              r_z   <= (oprnd == 4'h0);
            end
            4'h2: begin
              r_acc <= w_sum[3:0];
              r_c   <= w_sum[4];
              r_z   <= (w_sum[3:0] == 4'h0);
            end
            4'h3: begin
              r_acc <= w_diff[3:0];
              r_c   <= w_c_sub;
              r_z   <= (w_diff[3:0] == 4'h0);
            end
            4'h4: begin
              r_acc <= w_nand;
              r_z   <= (w_nand == 4'h0);
            end
            4'h5: begin
              r_acc <= data_in;
              r_z   <= (data_in == 4'h0);
            end
            4'h6: begin
              r_dout <= r_acc;
              r_strb <= 1'b1;
            end
            4'h7: begin
              r_c <= w_c_sub;
              r_z <= (w_diff[3:0] == 4'h0);
            end
            default: ;
          endcase
          if (w_jmp) r_state <= JADDR;
          else       r_state <= run ? FETCH : IDLE;
        end
        JADDR: begin
          r_state <= run ? FETCH : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by reset so a reset cycle never lets a partial
  // jump or increment land in the PC.
  assign fetch_en   = reset & (r_state == FETCH);
  assign pc_en      = reset & ((r_state == EXEC) |
                               ((r_state == JADDR) & ~r_take));
  assign pc_load    = reset & (r_state == JADDR) & r_take;
  assign pc_addr    = pc_load ? {r_hi, program_byte} : 12'h000;
  assign out_strobe = reset & r_strb;

  assign acc      = r_acc;
  assign flag_c   = r_c;
  assign flag_z   = r_z;
  assign data_out = r_dout;

endmodule

// File: tb/tb_decode_exec_unit.sv
// tb_decode_exec_unit: ROM/PC/fetch-register environment with an
// ISA-level model feeding a per-instruction scoreboard.
module tb_decode_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic [7:0]  program_byte;
  logic [3:0]  data_in;
  logic        fetch_en;
  logic        pc_en;
  logic        pc_load;
  logic [11:0] pc_addr;
  logic [3:0]  acc;
  logic        flag_c;
  logic        flag_z;
  logic [3:0]  data_out;
  logic        out_strobe;

  decode_exec_unit dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .instr        (instr),
    .oprnd        (oprnd),
    .program_byte (program_byte),
    .data_in      (data_in),
    .fetch_en     (fetch_en),
    .pc_en        (pc_en),
    .pc_load      (pc_load),
    .pc_addr      (pc_addr),
    .acc          (acc),
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .data_out     (data_out),
    .out_strobe   (out_strobe)
  );

  always #5 clk = ~clk;

  logic [7:0]  rom [0:4095];
  logic [11:0] pc;

  assign program_byte = rom[pc];

  always @(posedge clk) begin
    if (!reset) begin
      pc    <= 12'h000;
      instr <= 4'h0;
      oprnd <= 4'h0;
    end else begin
      if (fetch_en) {instr, oprnd} <= rom[pc];
      if (pc_load)    pc <= pc_addr;
      else if (pc_en) pc <= pc + 12'h001;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] a;
    logic       c;
    logic       z;
    logic [3:0] o;
    logic       s;
    logic       f;
  } exp_t;

  typedef struct packed {
    logic        t;
    logic [11:0] tgt;
  } jexp_t;

  exp_t  sbq[$];
  jexp_t jq[$];

  logic [3:0]  m_a, m_o, m_din;
  logic        m_c, m_z;
  logic [11:0] m_pc;

  task automatic model_run(input int n, input bit last_run);
    logic [7:0]  b;
    logic [3:0]  op, v;
    logic [4:0]  r;
    logic        s, tk, isj, f;
    logic [11:0] tgt;
    for (int k = 0; k < n; k++) begin
      b = rom[m_pc];
      op = b[7:4];
      v = b[3:0];
      m_pc = m_pc + 12'h001;
      s = 1'b0;
      tk = 1'b0;
      isj = 1'b0;
      case (op)
        4'h1: begin m_a = v; m_z = (m_a == 4'h0); end
        4'h2: begin
          r = {1'b0, m_a} + {1'b0, v};
          m_c = r[4];
          m_a = r[3:0];
          m_z = (m_a == 4'h0);
        end
        4'h3: begin
          m_c = (m_a < v);
          m_a = m_a - v;
          m_z = (m_a == 4'h0);
        end
        4'h4: begin m_a = ~(m_a & v); m_z = (m_a == 4'h0); end
        4'h5: begin m_a = m_din; m_z = (m_a == 4'h0); end
        4'h6: begin m_o = m_a; s = 1'b1; end
        4'h7: begin m_c = (m_a < v); m_z = (m_a == v); end
        4'h8: begin isj = 1'b1; tk = m_c; end
        4'h9: begin isj = 1'b1; tk = ~m_c; end
        4'hA: begin isj = 1'b1; tk = m_z; end
        4'hB: begin isj = 1'b1; tk = ~m_z; end
        4'hC: begin isj = 1'b1; tk = 1'b1; end
        default: ;
      endcase
      if (isj) begin
        tgt = {v, rom[m_pc]};
        m_pc = tk ? tgt : m_pc + 12'h001;
        jq.push_back('{tk, tgt});
      end
      f = isj ? 1'b0 : ((k == n - 1) ? last_run : 1'b1);
      sbq.push_back('{m_a, m_c, m_z, m_o, s, f});
    end
  endtask

  logic chk_pending = 1'b0;
  logic is_jmp = 1'b0;
  logic prev_fetch = 1'b0;
  int   fetch_cnt = 0;
  exp_t  e;
  jexp_t j;

  // EXEC is the pc_en cycle right after a fetch; results show one cycle later
  always @(negedge clk) begin
    if (chk_pending) begin
      chk_pending = 1'b0;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("acc", {8'h0, acc}, {8'h0, e.a});
        check("flag_c", {11'h0, flag_c}, {11'h0, e.c});
        check("flag_z", {11'h0, flag_z}, {11'h0, e.z});
        check("data_out", {8'h0, data_out}, {8'h0, e.o});
        check("out_strobe", {11'h0, out_strobe}, {11'h0, e.s});
        check("next_fetch", {11'h0, fetch_en}, {11'h0, e.f});
        if (is_jmp && jq.size() > 0) begin
          j = jq.pop_front();
          check("jaddr_load", {11'h0, pc_load}, {11'h0, j.t});
          check("jaddr_pc_en", {11'h0, pc_en}, {11'h0, ~j.t});
          if (j.t) check("jaddr_addr", pc_addr, j.tgt);
        end
      end
    end
    if (reset && pc_en && prev_fetch) begin
      chk_pending = 1'b1;
      is_jmp = (instr >= 4'h8) && (instr <= 4'hC);
    end
    prev_fetch = reset && fetch_en;
    if (reset && fetch_en) fetch_cnt++;
  end

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sbq.size() > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    check("sb_drain", 12'(sbq.size()), 12'h0);
    check("jq_drain", 12'(jq.size()), 12'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  fc0;
    bit  found;
    reset = 1'b0;
    run = 1'b1;
    data_in = 4'h0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h19; rom[12'h001] = 8'h28;
    rom[12'h002] = 8'h13; rom[12'h003] = 8'h35;
    rom[12'h004] = 8'h7E; rom[12'h005] = 8'hC4;
    rom[12'h006] = 8'hA7;
    rom[12'h4A7] = 8'h15; rom[12'h4A8] = 8'hA0;
    rom[12'h4A9] = 8'h55; rom[12'h4AA] = 8'h50;
    rom[12'h4AB] = 8'h60; rom[12'h4AC] = 8'h17;
    rom[12'h4AD] = 8'h60; rom[12'h4AE] = 8'hF3;
    rom[12'h4AF] = 8'h4C; rom[12'h4B0] = 8'h90;
    rom[12'h4B1] = 8'h10;
    rom[12'h010] = 8'h80; rom[12'h011] = 8'h77;
    rom[12'h012] = 8'h25; rom[12'h013] = 8'hC0;
    rom[12'h014] = 8'h13;
    m_a = 4'h0; m_o = 4'h0; m_c = 1'b0; m_z = 1'b0;
    m_din = 4'h0; m_pc = 12'h000;
    model_run(18, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("rst_acc", {8'h0, acc}, 12'h0);
    check("rst_c", {11'h0, flag_c}, 12'h0);
    check("rst_z", {11'h0, flag_z}, 12'h0);
    check("rst_dout", {8'h0, data_out}, 12'h0);
    check("rst_strobes", {8'h0, fetch_en, pc_en, pc_load, out_strobe}, 12'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("first_fetch", {11'h0, fetch_en}, 12'h1);
    drain(200);

    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      #1;
      if (pc_load) found = 1'b1;
    end
    check("loop_jaddr_seen", {11'h0, found}, 12'h1);
    #1 reset = 1'b0;
    #1;
    check("rst_jaddr_load", {11'h0, pc_load}, 12'h0);
    check("rst_jaddr_pc_en", {11'h0, pc_en}, 12'h0);
    @(posedge clk);
    #1;
    check("rst2_regs", {3'h0, acc, flag_c, flag_z, data_out}, 12'h0);
    check("rst2_addr", pc_addr, 12'h0);

    rom[12'h000] = 8'h12; rom[12'h001] = 8'h23;
    rom[12'h002] = 8'h11;
    m_a = 4'h0; m_o = 4'h0; m_c = 1'b0; m_z = 1'b0; m_pc = 12'h000;
    model_run(2, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      #1;
      if (instr == 4'h2 && pc_en) found = 1'b1;
    end
    check("add_exec_seen", {11'h0, found}, 12'h1);
    run = 1'b0;
    fc0 = fetch_cnt;
    repeat (6) @(negedge clk);
    #1;
    check("stop_no_fetch", 12'(fetch_cnt - fc0), 12'h0);
    check("stop_acc", {8'h0, acc}, 12'h5);
    check("stop_pc", pc, 12'h002);
    check("stop_sb", 12'(sbq.size()), 12'h0);
    model_run(1, 1'b1);
    run = 1'b1;
    @(posedge clk);
    #1;
    check("resume_fetch", {11'h0, fetch_en}, 12'h1);
    check("resume_pc", pc, 12'h002);
    drain(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
